valid_ready_hs_pair: RTL and testbench

Self-checking demonstration link for the AXI-style valid/ready handshake. It contains two submodules wired back-to-back on an 8-bit data channel:
- `master_ready_valid_hs` produces an incrementing byte stream.
- `slave_valid_ready_hs` applies a programmable backpressure pattern and captures every accepted byte.

The pair is the reference handshake used by the tutorial top level.

---
 rtl/valid_ready_hs.sv | 217 +++++++++++++++++++++
 tb/tb_valid_ready_hs_pair.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_ready_hs.sv
// ---------------------------------------------------------------------------
// valid_ready_hs_pair: demonstration link for a valid/ready handshake.
//
// A master produces an incrementing byte stream. A slave applies a fixed,
// repeating backpressure pattern and captures every byte it accepts. A byte
// moves on a rising edge where m_valid and s_ready are both high.
//
// Ports (pair):
//   aclk    in   clock, all logic on the rising edge
//   rstn    in   synchronous reset, active HIGH (despite the name)
//   m_valid out  master payload valid (registered)
//   m_data  out  master payload, DATA_W bits
//   s_ready out  slave ready (registered, follows S_READY_PATTERN)
//   s_data  out  last payload accepted by the slave
//
// Parameters:
//   DATA_W          channel width
//   M_GAP           idle cycles the master inserts after each transfer (0..15)
//   S_READY_PATTERN slave ready bit for cycle i after reset is bit (i mod 8)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// master_ready_valid_hs: incrementing byte source.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | reset state, m_valid low; left on the first edge out of reset
//   ST_SEND | m_valid high, m_data held until s_ready accepts it
//   ST_GAP  | m_valid low for M_GAP cycles after a transfer
//
// Ports:
//   aclk, rstn  clock / synchronous active-high reset
//   s_ready     in   ready from the slave
//   m_data      out  payload, increments by one on each transfer
//   m_valid     out  payload valid, decoded from the state register only
// ---------------------------------------------------------------------------
module master_ready_valid_hs #(
    parameter int DATA_W = 8,
    parameter int M_GAP  = 0
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Gap timer is a down-counter: loaded with M_GAP-1 on the transfer edge,
    // the master returns to SEND on the edge where it reads zero. That gives
    // exactly M_GAP cycles with m_valid low.
    localparam logic [3:0] GAP_LOAD = (M_GAP > 0) ? 4'(M_GAP - 1) : 4'd0;
    localparam bit         HAS_GAP  = (M_GAP > 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_gap_cnt;
    logic [3:0]          w_gap_cnt_nxt;
    logic [DATA_W-1:0]   r_data;
    logic                w_xfer;

    assign w_xfer = (r_state == ST_SEND) && s_ready;

    // State register
    always_ff @(posedge aclk) begin
        if (rstn) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 4'd0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_xfer) begin
                r_data <= r_data + DATA_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer && HAS_GAP) begin
                    w_state_nxt   = ST_GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_gap_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Outputs: purely a function of registers, never of s_ready.
    always_comb begin
        m_valid = (r_state == ST_SEND);
        m_data  = r_data;
    end

endmodule

// ---------------------------------------------------------------------------
// slave_valid_ready_hs: patterned-backpressure sink.
//
// Ports:
//   aclk, rstn  clock / synchronous active-high reset
//   m_valid     in   valid from the master
//   m_data      in   payload from the master
//   s_ready     out  registered ready, S_READY_PATTERN[idx] each cycle
//   s_data      out  last accepted payload
// ---------------------------------------------------------------------------
module slave_valid_ready_hs #(
    parameter int           DATA_W          = 8,
    parameter logic [7:0]   S_READY_PATTERN = 8'hFF
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] s_data
);

    logic [2:0]        r_idx;
    logic              r_s_ready;
    logic [DATA_W-1:0] r_s_data;

    // Ready is deliberately independent of m_valid; it only walks the
    // pattern, so it may be high with nothing offered or low with a byte
    // pending.
    always_ff @(posedge aclk) begin
        if (rstn) begin
            r_idx     <= 3'd0;
            r_s_ready <= 1'b0;
            r_s_data  <= '0;
        end else begin
            r_s_ready <= S_READY_PATTERN[r_idx];
            r_idx     <= r_idx + 3'd1;
            if (m_valid && r_s_ready) begin
                r_s_data <= m_data;
            end
        end
    end

    assign s_ready = r_s_ready;
    assign s_data  = r_s_data;

endmodule

// ---------------------------------------------------------------------------
// valid_ready_hs_pair: master and slave wired back-to-back.
// ---------------------------------------------------------------------------
module valid_ready_hs_pair #(
    parameter int         DATA_W          = 8,
    parameter int         M_GAP           = 0,
    parameter logic [7:0] S_READY_PATTERN = 8'hFF
) (
    input  logic              aclk,
    input  logic              rstn,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] s_data
);

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_data;
    logic              w_s_ready;
    logic [DATA_W-1:0] w_s_data;

    master_ready_valid_hs #(
        .DATA_W (DATA_W),
        .M_GAP  (M_GAP)
    ) u_master (
        .aclk    (aclk),
        .rstn    (rstn),
        .s_ready (w_s_ready),
        .m_data  (w_m_data),
        .m_valid (w_m_valid)
    );

    slave_valid_ready_hs #(
        .DATA_W          (DATA_W),
        .S_READY_PATTERN (S_READY_PATTERN)
    ) u_slave (
        .aclk    (aclk),
        .rstn    (rstn),
        .m_valid (w_m_valid),
        .m_data  (w_m_data),
        .s_ready (w_s_ready),
        .s_data  (w_s_data)
    );

    assign m_valid = w_m_valid;
    assign m_data  = w_m_data;
    assign s_ready = w_s_ready;
    assign s_data  = w_s_data;

endmodule

// File: tb/tb_valid_ready_hs_pair.sv
// Bench for valid_ready_hs_pair: four instances with different gap/pattern
// settings, checked against a cycle-index based reference model.
module tb_valid_ready_hs_pair;

    localparam int         NI = 4;
    localparam logic [7:0] PAT [NI] = '{8'hFF, 8'h55, 8'hFF, 8'hB6};
    localparam int         GAP [NI] = '{0, 0, 2, 3};

    logic       clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] mv;
    logic [3:0] sr;
    logic [7:0] md [NI];
    logic [7:0] sd [NI];

    always #5 clk = ~clk;

    valid_ready_hs_pair #(.DATA_W(8), .M_GAP(0), .S_READY_PATTERN(8'hFF)) u_a (
        .aclk(clk), .rstn(rst[0]), .m_valid(mv[0]), .m_data(md[0]), .s_ready(sr[0]), .s_data(sd[0]));
    valid_ready_hs_pair #(.DATA_W(8), .M_GAP(0), .S_READY_PATTERN(8'h55)) u_b (
        .aclk(clk), .rstn(rst[1]), .m_valid(mv[1]), .m_data(md[1]), .s_ready(sr[1]), .s_data(sd[1]));
    valid_ready_hs_pair #(.DATA_W(8), .M_GAP(2), .S_READY_PATTERN(8'hFF)) u_c (
        .aclk(clk), .rstn(rst[2]), .m_valid(mv[2]), .m_data(md[2]), .s_ready(sr[2]), .s_data(sd[2]));
    valid_ready_hs_pair #(.DATA_W(8), .M_GAP(3), .S_READY_PATTERN(8'hB6)) u_d (
        .aclk(clk), .rstn(rst[3]), .m_valid(mv[3]), .m_data(md[3]), .s_ready(sr[3]), .s_data(sd[3]));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. k = non-reset edges since reset; after edge k the
    // ready bit is PAT[(k-1) mod 8]; valid is visible from edge vfrom on;
    // a transfer on edge k pushes vfrom to k+GAP; data = accepted count.
    int       k      [NI];
    int       vfrom  [NI];
    int       n_acc  [NI];
    bit       e_valid[NI];
    bit       e_ready[NI];
    bit [7:0] e_data [NI];
    bit [7:0] e_sdata[NI];

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic [7:0] p;
            bit         x;
            if (rst[i]) begin
                k[i] = 0; vfrom[i] = 1; n_acc[i] = 0;
                e_valid[i] = 0; e_ready[i] = 0; e_data[i] = 0; e_sdata[i] = 0;
            end else begin
                x = e_valid[i] && e_ready[i];
                if (x) begin
                    e_sdata[i] = e_data[i];
                    n_acc[i]++;
                end
                k[i]++;
                if (x) vfrom[i] = k[i] + GAP[i];
                p = PAT[i];
                e_valid[i] = (k[i] >= vfrom[i]);
                e_ready[i] = p[(k[i] - 1) % 8];
                e_data[i]  = 8'(n_acc[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] p;
        rst = 4'hF;
        repeat (10) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (mv[i] !== 1'b0 || md[i] !== 8'h00 || sr[i] !== 1'b0 || sd[i] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_zero inst%0d: got v=%b d=%h r=%b sd=%h, want all 0",
                             i, mv[i], md[i], sr[i], sd[i]);
                end
            end
        end
        rst = 4'h0;
        tick();
        for (int i = 0; i < NI; i++) begin
            p = PAT[i];
            n_tests++;
            if (mv[i] !== 1'b1 || sr[i] !== p[0] || md[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release inst%0d: got v=%b r=%b d=%h, want v=1 r=%b d=00",
                         i, mv[i], sr[i], md[i], p[0]);
            end
        end
    endtask

    // Instance 0: ready always high, no gap -> one byte per clock, wraps.
    task automatic test_full_rate();
        bit seen_ff = 0;
        bit seen_wrap = 0;
        for (int c = 0; c < 262; c++) begin
            tick();
            n_tests++;
            if (sd[0] !== e_sdata[0] || md[0] !== e_data[0] || mv[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL full_rate cyc%0d: got d=%h sd=%h v=%b, want d=%h sd=%h v=1",
                         c, md[0], sd[0], mv[0], e_data[0], e_sdata[0]);
            end
            if (seen_ff && sd[0] === 8'h00) seen_wrap = 1;
            if (sd[0] === 8'hFF) seen_ff = 1;
        end
        n_tests++;
        if (!seen_wrap) begin
            n_fail++;
            $display("FAIL full_rate_wrap: got seen_ff=%b seen_wrap=%b, want 1 1", seen_ff, seen_wrap);
        end
    endtask

    // Instance 1: alternate-cycle ready; valid/data must hold while stalled.
    task automatic test_backpressure();
        logic       pv = mv[1];
        logic       pr = sr[1];
        logic [7:0] pd = md[1];
        for (int c = 0; c < 40; c++) begin
            tick();
            if (pv && !pr) begin
                n_tests++;
                if (mv[1] !== 1'b1 || md[1] !== pd) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc%0d: got v=%b d=%h, want v=1 d=%h", c, mv[1], md[1], pd);
                end
            end
            n_tests++;
            if (sd[1] !== e_sdata[1] || sr[1] !== e_ready[1] || md[1] !== e_data[1]) begin
                n_fail++;
                $display("FAIL bp_stream cyc%0d: got d=%h r=%b sd=%h, want d=%h r=%b sd=%h",
                         c, md[1], sr[1], sd[1], e_data[1], e_ready[1], e_sdata[1]);
            end
            pv = mv[1]; pr = sr[1]; pd = md[1];
        end
    endtask

    // Instance 2: gap of 2 -> valid low for exactly 2 cycles after a transfer.
    task automatic test_gap();
        int run   = 0;
        bit armed = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (mv[2]) begin
                if (armed && run != 0) begin
                    n_tests++;
                    if (run != 2) begin
                        n_fail++;
                        $display("FAIL gap_len cyc%0d: got low run %0d, want 2", c, run);
                    end
                end
                run = 0;
                armed = 1;
            end else begin
                run++;
            end
            n_tests++;
            if (mv[2] !== e_valid[2] || md[2] !== e_data[2] || sd[2] !== e_sdata[2]) begin
                n_fail++;
                $display("FAIL gap_stream cyc%0d: got v=%b d=%h sd=%h, want v=%b d=%h sd=%h",
                         c, mv[2], md[2], sd[2], e_valid[2], e_data[2], e_sdata[2]);
            end
        end
    endtask

    // Instance 1: reset while byte 5 is stalled; stream must restart at 0.
    task automatic test_reset_mid();
        bit found = 0;
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (mv[1] === 1'b1 && sr[1] === 1'b0 && md[1] === 8'h05) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_find: got d=%h v=%b r=%b, want d=05 v=1 r=0 within 40 cycles",
                     md[1], mv[1], sr[1]);
        end
        rst[1] = 1'b1;
        tick();
        n_tests++;
        if (mv[1] !== 1'b0 || md[1] !== 8'h00 || sr[1] !== 1'b0 || sd[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_zero: got v=%b d=%h r=%b sd=%h, want all 0", mv[1], md[1], sr[1], sd[1]);
        end
        rst[1] = 1'b0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (mv[1] === 1'b1 && sr[1] === 1'b1) found = 1;
        end
        n_tests++;
        if (!found || md[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_first: got found=%b d=%h, want found=1 d=00", found, md[1]);
        end
        tick();
        n_tests++;
        if (sd[1] !== 8'h00 || md[1] !== 8'h01) begin
            n_fail++;
            $display("FAIL rst_mid_accept: got sd=%h d=%h, want sd=00 d=01", sd[1], md[1]);
        end
    endtask

    // All instances, random reset pulses, every output vs model every cycle.
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) rst[i] = ($urandom_range(0, 39) == 0);
            tick();
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (mv[i] !== e_valid[i] || md[i] !== e_data[i] ||
                    sr[i] !== e_ready[i] || sd[i] !== e_sdata[i]) begin
                    n_fail++;
                    $display("FAIL rand_outputs cyc%0d inst%0d: got v=%b d=%h r=%b sd=%h, want v=%b d=%h r=%b sd=%h",
                             c, i, mv[i], md[i], sr[i], sd[i],
                             e_valid[i], e_data[i], e_ready[i], e_sdata[i]);
                end
            end
        end
        rst = 4'h0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            k[i] = 0; vfrom[i] = 1; n_acc[i] = 0;
            e_valid[i] = 0; e_ready[i] = 0; e_data[i] = 0; e_sdata[i] = 0;
        end
        test_reset();
        test_full_rate();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
